// File: rtl/elevator_dispatch_fsm.sv
// Single-car SCAN dispatcher: walks 6 floors, dwells at stops, pulses clears for served calls.
// Latency: one registered cycle from request to action; no backpressure, clears are fire-and-forget pulses.
module elevator_dispatch_fsm #(
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 6,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] car_req,
   input  logic [9:0] hall_req,
   output logic [5:0] car_clr,
   output logic [9:0] hall_clr,
   output logic [2:0] floor,
   output logic       dir_up,
   output logic       moving,
   output logic       door_open
);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] timer, timer_n;
   logic [2:0]       floor_n;
   logic             dir_n, arrived, arrived_n;
   logic             moving_n, door_open_n;
   logic [5:0]       car_clr_n, car_clr_d;
   logic [9:0]       hall_clr_n, hall_clr_d;

   logic [5:0]       car_eff, fl_req;
   logic [9:0]       hall_eff;
   logic [3:0]       up_idx, dn_idx;
   logic             up_here, dn_here, dir_call, opp_call;
   logic             above, below, ahead, behind, serve, open_door;

   // Bits pulsed this cycle or last cycle are masked: the latch may lag one cycle behind a clear.
   always_comb begin
      car_eff  = car_req & ~(car_clr | car_clr_d);
      hall_eff = hall_req & ~(hall_clr | hall_clr_d);
      fl_req   = '0;
      above    = 1'b0;
      below    = 1'b0;
      for (int f = 0; f < 6; f++) begin
         fl_req[f] = car_eff[f];
         if (f < 5) fl_req[f] = fl_req[f] | hall_eff[f];
         if (f > 0) fl_req[f] = fl_req[f] | hall_eff[f+4];
         if (3'(f) > floor) above = above | fl_req[f];
         if (3'(f) < floor) below = below | fl_req[f];
      end
      up_idx   = {1'b0, floor};
      dn_idx   = {1'b0, floor} + 4'd4;
      up_here  = (floor != 3'd5) && hall_eff[up_idx];
      dn_here  = (floor != 3'd0) && hall_eff[dn_idx];
      dir_call = dir_up ? up_here : dn_here;
      opp_call = dir_up ? dn_here : up_here;
      ahead    = dir_up ? above : below;
      behind   = dir_up ? below : above;
      // An opposite-direction call here waits for the return sweep while work remains ahead.
      serve    = car_eff[floor] | dir_call | (opp_call & ~ahead);
   end

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      floor_n    = floor;
      dir_n      = dir_up;
      arrived_n  = 1'b0;
      car_clr_n  = '0;
      hall_clr_n = '0;
      open_door  = 1'b0;

      case (state)
         IDLE: begin
            if (serve) begin
               open_door = 1'b1;
            end else if (ahead) begin
               state_n = MOVE;
               timer_n = '0;
            end else if (behind) begin
               state_n = MOVE;
               timer_n = '0;
               dir_n   = ~dir_up;
            end
         end
         MOVE: begin
            if (arrived) begin
               if (serve || !ahead) open_door = 1'b1;
            end else if (timer == MOVE_LAST) begin
               timer_n   = '0;
               arrived_n = 1'b1;
               if (dir_up && floor != 3'd5)       floor_n = floor + 3'd1;
               else if (!dir_up && floor != 3'd0) floor_n = floor - 3'd1;
            end else begin
               timer_n = timer + CNT_W'(1);
            end
         end
         DOOR: begin
            if (timer == DOOR_LAST) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // Stop at the current floor: clear what is served and turn around if nothing lies ahead.
      if (open_door) begin
         state_n   = DOOR;
         timer_n   = '0;
         car_clr_n = car_eff & (6'b000001 << floor);
         if (up_here && (dir_up || !ahead))  hall_clr_n[up_idx] = 1'b1;
         if (dn_here && (!dir_up || !ahead)) hall_clr_n[dn_idx] = 1'b1;
         if (!ahead) dir_n = ~dir_up;
      end

      moving_n    = (state_n == MOVE);
      door_open_n = (state_n == DOOR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         floor      <= 3'd0;
         dir_up     <= 1'b1;
         arrived    <= 1'b0;
         moving     <= 1'b0;
         door_open  <= 1'b0;
         car_clr    <= '0;
         hall_clr   <= '0;
         car_clr_d  <= '0;
         hall_clr_d <= '0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         floor      <= floor_n;
         dir_up     <= dir_n;
         arrived    <= arrived_n;
         moving     <= moving_n;
         door_open  <= door_open_n;
         car_clr    <= car_clr_n;
         hall_clr   <= hall_clr_n;
         car_clr_d  <= car_clr;
         hall_clr_d <= hall_clr;
      end
   end

endmodule
